// File: rtl/uart_cmd_decoder_pkg.sv
// Shared definitions for the UART command-frame decoder: header default,
// error codes, FSM state encodings and a saturating counter helper.
package uart_cmd_decoder_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hAA;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_PARITY  = 3'd1;
  localparam logic [2:0] ERR_CSUM    = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_OVERRUN = 3'd4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CSUM = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte idle counter: counts while enabled, clears on clr_i or when
// disabled, and flags the terminal count (TIMEOUT_CYCLES-1).
module uart_byte_timeout #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 17
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) cnt_d = '0;
    else                cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = en_i && (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles HEADER/ADDR/DATA.../CSUM byte frames from the UART receiver into
// held address/data commands (valid/ready) and reports frame errors.
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int         DATA_BYTES     = 2,
  parameter logic [7:0] HEADER         = HEADER_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         TO_W           = 17
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_ready,
  input  logic [7:0]              rx_data,
  input  logic                    rx_error,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [7:0]              cmd_addr,
  output logic [8*DATA_BYTES-1:0] cmd_data,
  output logic                    frame_err,
  output logic [2:0]              err_code,
  output logic [7:0]              err_count,
  output logic [2:0]              dbg_state_o
);

  localparam int         DW       = 8 * DATA_BYTES;
  localparam logic [1:0] IDX_LAST = 2'(DATA_BYTES - 1);

  // cmd_valid/cmd_ready: the command is transferred on a cycle where both
  // are high; cmd_addr/cmd_data are stable from the rise of cmd_valid until
  // that transfer and keep their values afterwards.

  logic [2:0]    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    addr_sh_q, addr_sh_d;
  logic [DW-1:0] data_sh_q, data_sh_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [7:0]    cmd_addr_q, cmd_addr_d;
  logic [DW-1:0] cmd_data_q, cmd_data_d;
  logic          frame_err_q, frame_err_d;
  logic [2:0]    err_code_q, err_code_d;
  logic [7:0]    err_count_q, err_count_d;

  logic       err_hit;
  logic [2:0] err_sel;
  logic       in_frame;
  logic       hdr_ok;
  logic       to_tc;

  assign in_frame = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign hdr_ok   = rx_ready && !rx_error && (rx_data == HEADER);

  uart_byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_timeout (
    .clk  (clk),
    .reset(reset),
    .clr_i(rx_ready),
    .en_i (in_frame),
    .tc_o (to_tc)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    err_hit     = 1'b0;
    err_sel     = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        if (hdr_ok) begin
          state_d = ST_ADDR;
          csum_d  = 8'h00;
        end
      end
      ST_ADDR, ST_DATA, ST_CSUM: begin
        // A byte arriving on the terminal-count cycle takes priority.
        if (rx_ready) begin
          if (rx_error) begin
            err_hit = 1'b1;
            err_sel = ERR_PARITY;
            state_d = ST_IDLE;
          end else if (state_q == ST_ADDR) begin
            addr_sh_d = rx_data;
            csum_d    = csum_q ^ rx_data;
            idx_d     = 2'd0;
            state_d   = ST_DATA;
          end else if (state_q == ST_DATA) begin
            data_sh_d = (data_sh_q << 8) | DW'(rx_data);
            csum_d    = csum_q ^ rx_data;
            if (idx_q == IDX_LAST) state_d = ST_CSUM;
            else                   idx_d   = idx_q + 2'd1;
          end else if (rx_data == csum_q) begin
            cmd_addr_d  = addr_sh_q;
            cmd_data_d  = data_sh_q;
            cmd_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end else begin
            err_hit = 1'b1;
            err_sel = ERR_CSUM;
            state_d = ST_IDLE;
          end
        end else if (to_tc) begin
          err_hit = 1'b1;
          err_sel = ERR_TIMEOUT;
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = ST_IDLE;
          if (hdr_ok) begin
            state_d = ST_ADDR;
            csum_d  = 8'h00;
          end
        end else if (rx_ready) begin
          err_hit = 1'b1;
          err_sel = ERR_OVERRUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    frame_err_d = err_hit;
    err_code_d  = err_hit ? err_sel : err_code_q;
    err_count_d = err_hit ? sat_inc8(err_count_q) : err_count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      csum_q      <= 8'h00;
      addr_sh_q   <= 8'h00;
      data_sh_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= 8'h00;
      cmd_data_q  <= '0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_count_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      err_count_q <= err_count_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_data    = cmd_data_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign err_count   = err_count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: byte-level driver, negedge scoreboard for
// commands and error pulses, and one task per scenario.
module tb_uart_cmd_decoder;
  import uart_cmd_decoder_pkg::*;

  localparam int DB  = 2;
  localparam int TOC = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_ready;
  logic [7:0]    rx_data;
  logic          rx_error;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_addr;
  logic [8*DB-1:0] cmd_data;
  logic          frame_err;
  logic [2:0]    err_code;
  logic [7:0]    err_count;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_cmd_q[$];
  logic [10:0] exp_err_q[$];
  logic [7:0]  exp_cnt = 8'h00;
  logic        prev_valid = 1'b0;

  uart_cmd_decoder #(
    .DATA_BYTES    (DB),
    .HEADER        (8'hAA),
    .TIMEOUT_CYCLES(TOC),
    .TO_W          (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_error   (rx_error),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .err_count  (err_count),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Scoreboard: every command rise and every error pulse must match the queue head.
  always @(negedge clk) begin
    logic [23:0] ec;
    logic [10:0] ee;
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (cmd_valid && !prev_valid) begin
        checks++;
        if (exp_cmd_q.size() == 0) begin
          errors++;
          $display("FAIL sb_cmd unexpected command addr=%h data=%h", cmd_addr, cmd_data);
        end else begin
          ec = exp_cmd_q.pop_front();
          if ({cmd_addr, cmd_data} !== ec) begin
            errors++;
            $display("FAIL sb_cmd got=%h required=%h", {cmd_addr, cmd_data}, ec);
          end
        end
      end
      if (frame_err) begin
        checks++;
        if (exp_err_q.size() == 0) begin
          errors++;
          $display("FAIL sb_err unexpected pulse code=%0d count=%0d", err_code, err_count);
        end else begin
          ee = exp_err_q.pop_front();
          if ({err_code, err_count} !== ee) begin
            errors++;
            $display("FAIL sb_err got code=%0d count=%0d required code=%0d count=%0d",
                     err_code, err_count, ee[10:8], ee[7:0]);
          end
        end
      end
      prev_valid = cmd_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic err, input logic rdy);
    @(negedge clk);
    rx_ready  = 1'b1;
    rx_data   = b;
    rx_error  = err;
    cmd_ready = rdy;
    @(negedge clk);
    rx_ready  = 1'b0;
    rx_error  = 1'b0;
    cmd_ready = 1'b0;
  endtask

  task automatic push_err(input logic [2:0] code);
    exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
    exp_err_q.push_back({code, exp_cnt});
  endtask

  task automatic send_frame(input logic [7:0] addr, input logic [15:0] data, input logic [7:0] adj);
    logic [7:0] cs;
    cs = addr ^ data[15:8] ^ data[7:0] ^ adj;
    if (adj == 8'h00) exp_cmd_q.push_back({addr, data});
    else              push_err(ERR_CSUM);
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(addr, 1'b0, 1'b0);
    send_byte(data[15:8], 1'b0, 1'b0);
    send_byte(data[7:0], 1'b0, 1'b0);
    send_byte(cs, 1'b0, 1'b0);
  endtask

  task automatic accept();
    @(negedge clk);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL accept cmd_valid=%b required=0", cmd_valid);
    end
  endtask

  task automatic check_cmd(input string name, input logic [7:0] a, input logic [15:0] d);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_addr !== a || cmd_data !== d) begin
      errors++;
      $display("FAIL %s valid=%b addr=%h data=%h required valid=1 addr=%h data=%h",
               name, cmd_valid, cmd_addr, cmd_data, a, d);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_ready = 1'b0; rx_data = 8'h00; rx_error = 1'b0; cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_valid, cmd_addr, cmd_data, frame_err, err_code, err_count, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_state valid=%b addr=%h data=%h ferr=%b code=%0d cnt=%0d st=%0d required all 0",
               cmd_valid, cmd_addr, cmd_data, frame_err, err_code, err_count, dbg_state);
    end
    reset = 1'b0;
  endtask

  task automatic test_good_frame();
    int bad;
    send_frame(8'h10, 16'h1234, 8'h00);
    check_cmd("good_frame", 8'h10, 16'h1234);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (cmd_valid !== 1'b1 || cmd_addr !== 8'h10 || cmd_data !== 16'h1234) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable unstable_cycles=%0d required=0", bad);
    end
    accept();
    checks++;
    if (cmd_addr !== 8'h10 || cmd_data !== 16'h1234) begin
      errors++;
      $display("FAIL retain_after_accept addr=%h data=%h required 10/1234", cmd_addr, cmd_data);
    end
  endtask

  task automatic test_bad_csum();
    send_frame(8'h10, 16'h1234, 8'h01);
    checks++;
    if (frame_err !== 1'b1 || err_code !== ERR_CSUM || err_count !== exp_cnt || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_csum ferr=%b code=%0d cnt=%0d valid=%b required 1/2/%0d/0",
               frame_err, err_code, err_count, cmd_valid, exp_cnt);
    end
    @(negedge clk);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse_width ferr=%b required=0", frame_err);
    end
    send_frame(8'h42, 16'hBEEF, 8'h00);
    check_cmd("after_bad_csum", 8'h42, 16'hBEEF);
    accept();
  endtask

  task automatic test_parity();
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h10, 1'b0, 1'b0);
    push_err(ERR_PARITY);
    send_byte(8'h12, 1'b1, 1'b0);
    checks++;
    if (err_code !== ERR_PARITY || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL parity code=%0d state=%0d required code=1 state=0", err_code, dbg_state);
    end
    send_byte(8'h55, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (err_count !== exp_cnt || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL idle_garbage cnt=%0d state=%0d required cnt=%0d state=0", err_count, dbg_state, exp_cnt);
    end
  endtask

  task automatic test_timeout();
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h10, 1'b0, 1'b0);
    push_err(ERR_TIMEOUT);
    repeat (TOC - 1) @(negedge clk);
    checks++;
    if (frame_err !== 1'b0 || dbg_state !== ST_DATA) begin
      errors++;
      $display("FAIL timeout_early ferr=%b state=%0d required 0/%0d", frame_err, dbg_state, ST_DATA);
    end
    @(negedge clk);
    checks++;
    if (frame_err !== 1'b1 || err_code !== ERR_TIMEOUT || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL timeout ferr=%b code=%0d state=%0d required 1/3/0", frame_err, err_code, dbg_state);
    end
    repeat (5) @(negedge clk);
    // Byte lands on exactly the terminal-count cycle and must be accepted.
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h10, 1'b0, 1'b0);
    repeat (TOC - 2) @(negedge clk);
    exp_cmd_q.push_back({8'h10, 16'h1234});
    send_byte(8'h12, 1'b0, 1'b0);
    checks++;
    if (frame_err !== 1'b0 || dbg_state !== ST_DATA) begin
      errors++;
      $display("FAIL timeout_tc_byte ferr=%b state=%0d required 0/%0d", frame_err, dbg_state, ST_DATA);
    end
    send_byte(8'h34, 1'b0, 1'b0);
    send_byte(8'h36, 1'b0, 1'b0);
    check_cmd("tc_byte_frame", 8'h10, 16'h1234);
    accept();
  endtask

  task automatic test_overrun();
    send_frame(8'h5A, 16'hC3F0, 8'h00);
    check_cmd("overrun_setup", 8'h5A, 16'hC3F0);
    push_err(ERR_OVERRUN);
    send_byte(8'hAA, 1'b0, 1'b0);
    checks++;
    if (frame_err !== 1'b1 || err_code !== ERR_OVERRUN) begin
      errors++;
      $display("FAIL overrun ferr=%b code=%0d required 1/4", frame_err, err_code);
    end
    check_cmd("overrun_hold", 8'h5A, 16'hC3F0);
    send_byte(8'hAA, 1'b0, 1'b1);
    checks++;
    if (frame_err !== 1'b0 || cmd_valid !== 1'b0 || dbg_state !== ST_ADDR) begin
      errors++;
      $display("FAIL accept_with_header ferr=%b valid=%b state=%0d required 0/0/%0d",
               frame_err, cmd_valid, dbg_state, ST_ADDR);
    end
    exp_cmd_q.push_back({8'h20, 16'h0001});
    send_byte(8'h20, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h21, 1'b0, 1'b0);
    check_cmd("back_to_back", 8'h20, 16'h0001);
    accept();
  endtask

  task automatic test_saturation();
    repeat (260) begin
      send_frame(8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)),
                 8'($urandom_range(1, 255)));
    end
    @(negedge clk);
    checks++;
    if (err_count !== 8'd255 || err_code !== ERR_CSUM) begin
      errors++;
      $display("FAIL saturation cnt=%0d code=%0d required 255/2", err_count, err_code);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h10, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    checks++;
    if ({cmd_valid, cmd_addr, cmd_data, frame_err, err_code, err_count, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_mid_frame valid=%b addr=%h data=%h ferr=%b code=%0d cnt=%0d st=%0d required all 0",
               cmd_valid, cmd_addr, cmd_data, frame_err, err_code, err_count, dbg_state);
    end
    @(negedge clk);
    reset   = 1'b0;
    exp_cnt = 8'h00;
    send_frame(8'h77, 16'h0102, 8'h00);
    check_cmd("after_reset", 8'h77, 16'h0102);
    accept();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_parity();
    test_timeout();
    test_overrun();
    test_saturation();
    test_reset_mid_frame();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_cmd_q.size() != 0 || exp_err_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain cmd_left=%0d err_left=%0d required 0/0", exp_cmd_q.size(), exp_err_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
